// File: rtl/dot_seq_pkg.sv
// Shared types and widths for the dot-product sequencer.
package dot_seq_pkg;
  localparam int ACC_W  = 32;
  localparam int LANE_W = 32;

  typedef enum logic [1:0] {IDLE, RUN, DONE} dot_seq_state_t;
endpackage

// File: rtl/dot_seq_if.sv
// Job / chunk / result handshake bundle. DOT_SEQ_OVERFLOW_FLAG_EN adds out_overflow.
interface dot_seq_if
  import dot_seq_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = 5
);
  logic                  start;
  logic [CW-1:0]         num_chunks;
  logic                  busy;
  logic                  in_valid;
  logic                  in_ready;
  logic [N*LANE_W-1:0]   in_a;
  logic [N*LANE_W-1:0]   in_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_W-1:0]      out_result;
`ifdef DOT_SEQ_OVERFLOW_FLAG_EN
  logic                  out_overflow;

  modport master (output start, num_chunks, in_valid, in_a, in_b, out_ready,
                  input  busy, in_ready, out_valid, out_result, out_overflow);
  modport slave  (input  start, num_chunks, in_valid, in_a, in_b, out_ready,
                  output busy, in_ready, out_valid, out_result, out_overflow);
`else
  modport master (output start, num_chunks, in_valid, in_a, in_b, out_ready,
                  input  busy, in_ready, out_valid, out_result);
  modport slave  (input  start, num_chunks, in_valid, in_a, in_b, out_ready,
                  output busy, in_ready, out_valid, out_result);
`endif
endinterface

// File: rtl/dot_product.sv
// Combinational N-lane dot product; lane products and the sum truncate to 32 bits.
module dot_product
  import dot_seq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N*LANE_W-1:0] a_i,
  input  logic [N*LANE_W-1:0] b_i,
  output logic [ACC_W-1:0]    dp_o
);
  logic [N-1:0][ACC_W-1:0] prod;

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign prod[i] = a_i[i*LANE_W +: LANE_W] * b_i[i*LANE_W +: LANE_W];
  end

  always_comb begin
    dp_o = '0;
    for (int i = 0; i < N; i++) dp_o = dp_o + prod[i];
  end
endmodule

// File: rtl/dot_product_sequencer.sv
// Streams L chunks through dot_product, accumulates, returns one result per job.
// DOT_SEQ_OVERFLOW_FLAG_EN adds a sticky accumulator carry-out flag.
module dot_product_sequencer
  import dot_seq_pkg::*;
#(
  parameter int N          = 8,
  parameter int MAX_CHUNKS = 16
) (
  input logic     clk,
  input logic     rst_n,
  dot_seq_if.slave bus
);
  localparam int CW = $clog2(MAX_CHUNKS+1);

  dot_seq_state_t   state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic [ACC_W-1:0] dp;
  logic [CW-1:0]    len_clamp;
  logic             xfer;

  dot_product #(.N(N)) u_dp (.a_i(bus.in_a), .b_i(bus.in_b), .dp_o(dp));

`ifdef DOT_SEQ_OVERFLOW_FLAG_EN
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum;
  assign sum = {1'b0, acc_q} + {1'b0, dp};
`else
  logic [ACC_W-1:0] sum;
  assign sum = acc_q + dp;
`endif

  assign len_clamp = (bus.num_chunks > CW'(MAX_CHUNKS)) ? CW'(MAX_CHUNKS) : bus.num_chunks;
  assign xfer      = (state_q == RUN) && bus.in_valid;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
`ifdef DOT_SEQ_OVERFLOW_FLAG_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: if (bus.start) begin
        acc_d   = '0;
        rem_d   = len_clamp;
        state_d = (len_clamp == '0) ? DONE : RUN;
`ifdef DOT_SEQ_OVERFLOW_FLAG_EN
        ovf_d   = 1'b0;
`endif
      end
      RUN: if (xfer) begin
        acc_d = sum[ACC_W-1:0];
        rem_d = rem_q - 1'b1;
        if (rem_q == CW'(1)) state_d = DONE;
`ifdef DOT_SEQ_OVERFLOW_FLAG_EN
        ovf_d = ovf_q | sum[ACC_W];
`endif
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
`ifdef DOT_SEQ_OVERFLOW_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
`ifdef DOT_SEQ_OVERFLOW_FLAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Outputs are pure state decode or registers: no in_valid/out_ready feedthrough.
  assign bus.busy       = (state_q != IDLE);
  assign bus.in_ready   = (state_q == RUN);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.out_result = acc_q;
`ifdef DOT_SEQ_OVERFLOW_FLAG_EN
  assign bus.out_overflow = ovf_q;
`endif
endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed self-checking bench for dot_product_sequencer (N=8, MAX_CHUNKS=16).
module tb_dot_product_sequencer;
  localparam int N  = 8;
  localparam int MC = 16;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   xfers = 0;

  always #5 clk = ~clk;

  dot_seq_if #(.N(N), .CW(CW)) bus ();

  dot_product_sequencer #(.N(N), .MAX_CHUNKS(MC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always @(posedge clk) if (bus.in_valid && bus.in_ready) xfers <= xfers + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*32-1:0] fill(input logic [31:0] v);
    logic [N*32-1:0] r;
    for (int i = 0; i < N; i++) r[i*32 +: 32] = v;
    return r;
  endfunction

  task automatic start_job(input int len);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.num_chunks = CW'(len);
    @(negedge clk);
    bus.start      = 1'b0;
  endtask

  // Offer one chunk at a negedge, wait (bounded) for in_ready, return after transfer.
  task automatic send(input logic [N*32-1:0] a, input logic [N*32-1:0] b);
    int t;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 20) begin @(negedge clk); t++; end
    if (t >= 20) chk("send_timeout", 32'(t), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("drain_out_valid", 32'(bus.out_valid), 32'd0);
    chk("drain_busy",      32'(bus.busy),      32'd0);
  endtask

  initial begin
    int x0;
    logic [N*32-1:0] wa;
    bus.start = 1'b0; bus.num_chunks = '0; bus.in_valid = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result",    bus.out_result,     32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Single chunk: 8 lanes * 2*3 = 48
    start_job(1);
    chk("s1_busy", 32'(bus.busy), 32'd1);
    send(fill(32'd2), fill(32'd3));
    chk("s1_out_valid", 32'(bus.out_valid), 32'd1);
    chk("s1_result",    bus.out_result,     32'd48);
    drain();

    // Four chunks with bubbles, then 5 cycles of backpressure: 8*(1+2+3+4)=80
    start_job(4);
    for (int k = 0; k < 4; k++) begin
      send(fill(32'(k+1)), fill(32'd1));
      if (k < 3) begin
        chk("mc_no_valid_mid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("mc_bubble_busy", 32'(bus.busy), 32'd1);
      end
    end
    for (int c = 0; c < 5; c++) begin
      chk("mc_hold_valid",  32'(bus.out_valid), 32'd1);
      chk("mc_hold_result", bus.out_result,     32'd80);
      @(negedge clk);
    end
    chk("mc_result", bus.out_result, 32'd80);
    drain();

    // Empty job: result 0 next cycle, data offered is never taken
    x0 = xfers;
    bus.in_valid = 1'b1; bus.in_a = fill(32'd7); bus.in_b = fill(32'd7);
    start_job(0);
    chk("e_out_valid", 32'(bus.out_valid), 32'd1);
    chk("e_result",    bus.out_result,     32'd0);
    chk("e_in_ready",  32'(bus.in_ready),  32'd0);
    @(negedge clk);
    chk("e_in_ready2", 32'(bus.in_ready),  32'd0);
    bus.in_valid = 1'b0;
    chk("e_no_xfer",   32'(xfers - x0),    32'd0);
    drain();

    // Wrap: 0xFFFFFFFF + 0xFFFFFFFF mod 2^32
    wa = '0; wa[31:0] = 32'hFFFF_FFFF;
    start_job(2);
    send(wa, fill(32'd1));
`ifdef DOT_SEQ_OVERFLOW_FLAG_EN
    chk("w_ovf_first", 32'(bus.out_overflow), 32'd0);
`endif
    send(wa, fill(32'd1));
    chk("w_out_valid", 32'(bus.out_valid), 32'd1);
    chk("w_result",    bus.out_result,     32'hFFFF_FFFE);
`ifdef DOT_SEQ_OVERFLOW_FLAG_EN
    chk("w_ovf", 32'(bus.out_overflow), 32'd1);
`endif
    drain();

    // Clamp L=19 to 16, second start during RUN ignored; 16*8 = 128
    x0 = xfers;
    start_job(MC + 3);
    bus.in_valid = 1'b1; bus.in_a = fill(32'd1); bus.in_b = fill(32'd1);
    for (int c = 0; c < MC; c++) begin
      chk("cl_not_done", 32'(bus.out_valid), 32'd0);
      bus.start = (c == 3); bus.num_chunks = CW'(2);
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("cl_out_valid", 32'(bus.out_valid), 32'd1);
    chk("cl_xfers",     32'(xfers - x0),    32'd16);
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    chk("cl_xfers_hold", 32'(xfers - x0),   32'd16);
    chk("cl_result",     bus.out_result,    32'd128);
    drain();
    @(negedge clk);
    chk("cl_no_requeue", 32'(bus.busy), 32'd0);

    // Reset mid-job after 2 of 4 chunks, then a clean L=1 job
    start_job(4);
    send(fill(32'd5), fill(32'd1));
    send(fill(32'd5), fill(32'd1));
    rst_n = 1'b0;
    #1;
    chk("mr_busy",      32'(bus.busy),      32'd0);
    chk("mr_in_ready",  32'(bus.in_ready),  32'd0);
    chk("mr_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mr_result",    bus.out_result,     32'd0);
    @(negedge clk); rst_n = 1'b1;
    start_job(1);
    send(fill(32'd2), fill(32'd3));
    chk("mr_new_valid",  32'(bus.out_valid), 32'd1);
    chk("mr_new_result", bus.out_result,     32'd48);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/dot_product_sequencer.md
# dot_product_sequencer

Controller that computes long-vector dot products on the N-lane combinational `dot_product` datapath. A job of L chunks, each N lanes wide, is streamed through the datapath at one chunk per cycle. The partial sums are accumulated in a 32-bit register, and one result is returned per job over a valid/ready handshake. The block sits between a vector source (memory reader or DMA) and any consumer of scalar results.

## Interface
Parameters:
- `N`, 8, lanes per chunk (32 bits each); passed to the datapath.
- `MAX_CHUNKS`, 16, maximum chunks per job; `CW = $clog2(MAX_CHUNKS+1)`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  job request; sampled only in IDLE.
- `num_chunks`  in  CW  job length L, sampled with `start`.
- `busy`  out  1  high in every state except IDLE.
- `in_valid`  in  1  chunk available.
- `in_ready`  out  1  chunk accepted this cycle when `in_valid` is also high.
- `in_a`, `in_b`  in  32*N  packed chunk operands; lane i is bits [32i+31:32i].
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `out_result`  out  32  job dot product.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE → RUN when `start`=1 and L≠0.
  - Load `remaining`=min(L, MAX_CHUNKS) and clear `acc`=0.
- IDLE → DONE when `start`=1 and L=0.
  - `acc`=0 is presented as the result.
- RUN behaviour:
  - `in_ready`=1.
  - On each `in_valid && in_ready`: `acc <= acc + dp(in_a,in_b)` and `remaining <= remaining-1`.
  - The transfer with `remaining`=1 moves the FSM to DONE.
  - `in_valid`=0 is a bubble: no change to state or counters.
- DONE behaviour:
  - `out_valid`=1 and `out_result`=`acc`, both held stable until `out_ready`=1.
  - On that handshake the FSM moves to IDLE.
- `start` outside IDLE is ignored. It is not queued.
- `in_ready`=0 in IDLE and DONE, so input data offered in those states is not consumed.
- Arithmetic is unsigned, modulo 2^32.
  - Lane products and the reduction are truncated to 32 bits by the datapath.
  - The accumulator add wraps.
- L > MAX_CHUNKS is clamped to MAX_CHUNKS.

## Timing
- Reset (asynchronous assert, synchronous release):
  - FSM=IDLE, `acc`=0, `remaining`=0.
  - `busy`=0, `in_ready`=0, `out_valid`=0, `out_result`=0.
- Reset mid-job aborts the job immediately. No result is produced.
- Throughput: one chunk per cycle in RUN.
- Latency: `out_valid` rises on the cycle after the last chunk is accepted.
  - Total for L gap-free chunks: start cycle + L transfer cycles + 1.
- L=0: `out_valid` rises on the cycle after `start`.
- Back-to-back jobs: the `out_ready` handshake cycle returns the FSM to IDLE, and the next `start` is sampled on the following cycle. The minimum gap between jobs is one IDLE cycle.
- All outputs come directly from registers or decode of the FSM state. There is no combinational path from `in_valid` or `out_ready` to any output.

## Configuration
- `DOT_SEQ_OVERFLOW_FLAG_EN` defined:
  - Adds output `out_overflow` (1 bit) and a sticky flag register.
  - The flag is cleared at job start and set on any carry-out of the accumulator add.
  - `out_overflow` is valid with `out_valid` and resets to 0.
- Not defined: the port and the register are absent, and the wrap behaviour is unchanged.

## Structure
- Package `dot_seq_pkg` holds:
  - the state enum `dot_seq_state_t` (IDLE, RUN, DONE);
  - `ACC_W`=32 and `LANE_W`=32.
- Sub-module: one instance of `dot_product #(N)`, driven directly from `in_a`/`in_b`. Its output is the per-chunk partial sum.
- No other hierarchy.

## Test plan
- Single-chunk job:
  - Stimulus: reset; L=1; all lanes a=2, b=3 (N=8).
  - Required: `out_result`=48, with `out_valid` one cycle after the transfer.
- Multi-chunk job with bubbles and output backpressure:
  - Stimulus: L=4, chunk k has all lanes a=k+1, b=1; `in_valid` toggled every other cycle; `out_ready` held low for 5 cycles.
  - Required: `out_result`=80, held stable throughout the backpressure.
- Empty job:
  - Stimulus: L=0.
  - Required: `out_valid` on the next cycle with `out_result`=0; `in_ready` never asserts.
- Wrap-around:
  - Stimulus: L=2, lane0 a=0xFFFF_FFFF, b=1 in both chunks, all other lanes 0.
  - Required: `out_result`=0xFFFF_FFFE.
  - With `DOT_SEQ_OVERFLOW_FLAG_EN`: `out_overflow`=1.
- Clamp and ignored start:
  - Stimulus: L=MAX_CHUNKS+3; pulse `start` again during RUN.
  - Required: exactly 16 transfers, one result, and the second `start` has no effect.
- Reset mid-job:
  - Stimulus: assert `rst_n`=0 after 2 of 4 chunks.
  - Required: all outputs 0 immediately; a new job of L=1 afterwards returns the correct value with no leftover accumulation.
